// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache (8 lines x 4 words)
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   proc_read, proc_write      CPU request (both high is treated as a write)
//   proc_addr[29:0]            CPU word address: tag [29:5], index [4:2], offset [1:0]
//   proc_wdata[31:0]           CPU write data
//   proc_stall                 request cannot complete this cycle
//   proc_rdata[31:0]           read data, valid when proc_read && !proc_stall
//   mem_read, mem_write        line read / line write request to memory
//   mem_addr[27:0]             memory line address
//   mem_wdata[127:0]           victim line for write-back (word k at [32k+31:32k])
//   mem_rdata[127:0]           refill line from memory
//   mem_ready                  one-cycle completion pulse from memory
//   hit_cnt, miss_cnt [31:0]   saturating statistics, present only with DCACHE_PERF_EN
//
// Optional feature macro: DCACHE_PERF_EN
module dcache #(
    parameter int NSETS = 8,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [29:0]           proc_addr,
    input  logic [31:0]           proc_wdata,
    output logic                  proc_stall,
    output logic [31:0]           proc_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [27:0]           mem_addr,
    output logic [32*WORDS-1:0]   mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_ready
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t state, next_state;
    logic [NSETS-1:0] valid, dirty;
    logic [24:0] tags [NSETS];
    logic [32*WORDS-1:0] data [NSETS];
    logic [2:0] idx;
    logic [1:0] off;
    logic [24:0] tag_in;
    logic req, hit, refill;
    assign idx    = proc_addr[4:2];
    assign off    = proc_addr[1:0];
    assign tag_in = proc_addr[29:5];
    assign req    = proc_read | proc_write;
    assign hit    = (state == IDLE) && req && valid[idx] && (tags[idx] == tag_in);
    assign refill = (state == ALLOCATE) && mem_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req && !hit) next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem_ready) next_state = ALLOCATE;
            ALLOCATE:  if (mem_ready) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end
    // The CPU holds its request through a miss, so the victim tag and the
    // refill address both come straight from the current proc_addr.
    always_comb begin
        mem_read   = state == ALLOCATE;
        mem_write  = state == WRITEBACK;
        proc_stall = (state != IDLE) || (req && !hit);
        mem_addr   = (state == WRITEBACK) ? {tags[idx], idx} : proc_addr[29:2];
        mem_wdata  = data[idx];
        proc_rdata = data[idx][{off, 5'b0} +: 32];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (refill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (hit && proc_write) begin
            dirty[idx] <= 1'b1;
        end
    end
    // Tag and data storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (refill) begin
            data[idx] <= mem_rdata;
            tags[idx] <= tag_in;
        end else if (hit && proc_write) begin
            data[idx][{off, 5'b0} +: 32] <= proc_wdata;
        end
    end
`ifdef DCACHE_PERF_EN
    // The hit that completes a refilled request is part of that miss, not a new hit.
    logic after_alloc;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            after_alloc <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            after_alloc <= refill;
            if (hit && !after_alloc && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (state == IDLE && req && !hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule
